pc_fetch_unit: RTL and testbench
================================

# pc_fetch_unit

Program-counter and instruction-fetch stage directly downstream of the branch-decision logic: it consumes the branch unit's PC-select bit together with the computed target and holds the architectural PC. It fetches each instruction over a request/valid handshake with instruction memory and presents it to decode. It then waits for the core's commit strobe before advancing the PC to either PC+4 or the target. It also flags misaligned control-flow targets and counts retired instructions.

## Interface
- XLEN, 32, address/data width
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- CLK  in  1  clock, all state updates on rising edge
- RST  in  1  reset, asynchronous, active-high
- PC_Sel  in  1  from branch logic: 1 = take PC_TARGET, 0 = PC+4
- PC_TARGET  in  XLEN  branch/JAL/JALR target from ALU
- INSTR_ACK  in  1  core has finished executing the presented instruction
- IMEM_REQ  out  1  fetch request to instruction memory
- IMEM_ADDR  out  XLEN  fetch address (equals PC)
- IMEM_RVALID  in  1  IMEM_RDATA valid for the outstanding request
- IMEM_RDATA  in  32  fetched instruction word
- INSTR  out  32  latched instruction for decode
- INSTR_VALID  out  1  INSTR is valid and awaiting INSTR_ACK
- PC  out  XLEN  address of INSTR
- PC_PLUS4  out  XLEN  PC+4 (link value for JAL/JALR)
- FAULT  out  1  sticky misaligned-target fault
- RETIRE_CNT  out  32  count of accepted INSTR_ACKs

## Operation
- States: S_IDLE, S_REQ, S_EXEC, S_FAULT.
- S_IDLE: entered on reset; unconditionally to S_REQ next cycle.
- S_REQ: IMEM_REQ=1, IMEM_ADDR=PC; held until IMEM_RVALID=1. On RVALID: INSTR<=IMEM_RDATA, go S_EXEC. INSTR_ACK ignored here.
- S_EXEC: INSTR_VALID=1, IMEM_REQ=0; IMEM_RVALID ignored. On INSTR_ACK:
  - next = PC_Sel ? {PC_TARGET[XLEN-1:1],1'b0} : PC+4 (bit 0 always cleared, covers JALR).
  - RETIRE_CNT <= RETIRE_CNT+1 (wraps at 2^32).
  - next[1]==1: PC unchanged, FAULT<=1, go S_FAULT.
  - else PC<=next, go S_REQ.
- S_FAULT: terminal until RST; IMEM_REQ=0, INSTR_VALID=0, FAULT=1, PC frozen at faulting instruction.
- Arithmetic: PC+4 modulo 2^XLEN; 32'hFFFF_FFFC+4 = 0, no flag.
- PC_PLUS4 is combinational PC+4, always consistent with PC.

## Timing
- Reset values: PC=RESET_PC, PC_PLUS4=RESET_PC+4, INSTR=32'h0000_0013 (NOP), INSTR_VALID=0, IMEM_REQ=0, FAULT=0, RETIRE_CNT=0, state S_IDLE.
- RST assertion takes effect immediately (no clock), including mid-request: IMEM_REQ drops combinationally with state.
- First IMEM_REQ: first rising edge after RST deasserts moves to S_REQ; IMEM_REQ high the cycle after.
- Zero-wait memory (RVALID in first REQ cycle): INSTR_VALID high next cycle; minimum 2 cycles/instruction (REQ, EXEC with same-cycle ACK).
- IMEM_ADDR stable for the whole S_REQ dwell; no second request before RVALID.
- INSTR, PC stable throughout S_EXEC until the ACK edge.
- PC_Sel/PC_TARGET sampled only on the edge where S_EXEC and INSTR_ACK coincide.

## Structure
- Package fetch_pkg: state enum typedef (S_IDLE/S_REQ/S_EXEC/S_FAULT), NOP_INSTR constant 32'h0000_0013, default RESET_PC.
- One sub-module: pc_next_calc (combinational: PC, PC_Sel, PC_TARGET -> next PC, misalign flag); FSM, registers and counter stay in pc_fetch_unit.

## Test plan
- Reset then zero-wait memory returning 0x00000013, ACK with PC_Sel=0 each time -> IMEM_ADDR sequence 0x0,0x4,0x8; RETIRE_CNT=3 after 3 ACKs.
- Memory delays RVALID 3 cycles -> IMEM_REQ held 4 cycles with IMEM_ADDR constant; INSTR_VALID rises exactly one cycle after RVALID.
- ACK with PC_Sel=1, PC_TARGET=0x00000101 -> next IMEM_ADDR=0x00000100 (bit 0 cleared), PC_PLUS4=0x104.
- ACK with PC_Sel=1, PC_TARGET=0x00000202 -> FAULT=1, PC unchanged, IMEM_REQ stays 0, RETIRE_CNT incremented; persists until RST.
- RESET_PC=0xFFFFFFFC, ACK with PC_Sel=0 -> next IMEM_ADDR=0x00000000, FAULT=0.
- RST asserted mid-S_REQ (between edges) -> IMEM_REQ and INSTR_VALID drop immediately, PC=RESET_PC; INSTR_ACK pulses during S_REQ do not change PC or RETIRE_CNT.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the program-counter / instruction-fetch stage.
package fetch_pkg;

  localparam int          XLEN_DEFAULT     = 32;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_EXEC  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection: sequential PC+4 or a control-flow target with bit 0 cleared.
module pc_next_calc #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic            pc_sel,
  input  logic [XLEN-1:0] pc_target,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] next_pc,
  output logic            misalign
);

  assign pc_plus4 = pc + XLEN'(4);

  // JALR semantics: the low bit of a target is always discarded; bit 1 still flags misalignment.
  always_comb begin
    next_pc  = pc_plus4;
    if (pc_sel) begin
      next_pc = pc_target & ~XLEN'(1);
    end
    misalign = next_pc[1];
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Holds the architectural PC, fetches one instruction at a time from IMEM and waits for commit.
module pc_fetch_unit
  import fetch_pkg::*;
#(
  parameter int             XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            PC_Sel,
  input  logic [XLEN-1:0] PC_TARGET,
  input  logic            INSTR_ACK,
  output logic            IMEM_REQ,
  output logic [XLEN-1:0] IMEM_ADDR,
  input  logic            IMEM_RVALID,
  input  logic [31:0]     IMEM_RDATA,
  output logic [31:0]     INSTR,
  output logic            INSTR_VALID,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PC_PLUS4,
  output logic            FAULT,
  output logic [31:0]     RETIRE_CNT,
  output state_t          state_dbg
);

  // Handshakes: IMEM_REQ stays high with a stable IMEM_ADDR until the edge that samples
  // IMEM_RVALID=1; INSTR_VALID stays high with stable INSTR/PC until the edge that samples
  // INSTR_ACK=1. Either response outside its owning state is ignored.

  state_t          state;
  logic [XLEN-1:0] pc_q;
  logic [31:0]     instr_q;
  logic            imem_req_q;
  logic            instr_valid_q;
  logic            fault_q;
  logic [31:0]     retire_cnt_q;

  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] next_pc;
  logic            misalign;

  pc_next_calc #(
    .XLEN(XLEN)
  ) u_next (
    .pc        (pc_q),
    .pc_sel    (PC_Sel),
    .pc_target (PC_TARGET),
    .pc_plus4  (pc_plus4),
    .next_pc   (next_pc),
    .misalign  (misalign)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state         <= S_IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= NOP_INSTR;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      fault_q       <= 1'b0;
      retire_cnt_q  <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          state      <= S_REQ;
          imem_req_q <= 1'b1;
        end
        S_REQ: begin
          if (IMEM_RVALID) begin
            instr_q       <= IMEM_RDATA;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b1;
            state         <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (INSTR_ACK) begin
            retire_cnt_q  <= retire_cnt_q + 32'd1;
            instr_valid_q <= 1'b0;
            // A misaligned target parks the PC on the instruction that produced it.
            if (misalign) begin
              fault_q <= 1'b1;
              state   <= S_FAULT;
            end else begin
              pc_q       <= next_pc;
              imem_req_q <= 1'b1;
              state      <= S_REQ;
            end
          end
        end
        S_FAULT: begin
          imem_req_q    <= 1'b0;
          instr_valid_q <= 1'b0;
          fault_q       <= 1'b1;
        end
        default: begin
          state         <= S_IDLE;
          imem_req_q    <= 1'b0;
          instr_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign IMEM_REQ    = imem_req_q;
  assign IMEM_ADDR   = pc_q;
  assign INSTR       = instr_q;
  assign INSTR_VALID = instr_valid_q;
  assign PC          = pc_q;
  assign PC_PLUS4    = pc_plus4;
  assign FAULT       = fault_q;
  assign RETIRE_CNT  = retire_cnt_q;
  assign state_dbg   = state;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: fetch driver, commit driver and a PC/INSTR scoreboard.
module tb_pc_fetch_unit;
  import fetch_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT 0 : RESET_PC = 0 ----------------
  logic        pc_sel = 1'b0;
  logic [31:0] pc_target = 32'd0;
  logic        instr_ack = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fault;
  logic [31:0] retire_cnt;
  state_t      state_dbg;

  pc_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .CLK(clk), .RST(rst), .PC_Sel(pc_sel), .PC_TARGET(pc_target), .INSTR_ACK(instr_ack),
    .IMEM_REQ(imem_req), .IMEM_ADDR(imem_addr), .IMEM_RVALID(imem_rvalid), .IMEM_RDATA(imem_rdata),
    .INSTR(instr), .INSTR_VALID(instr_valid), .PC(pc), .PC_PLUS4(pc_plus4), .FAULT(fault),
    .RETIRE_CNT(retire_cnt), .state_dbg(state_dbg)
  );

  // ---------------- DUT 1 : RESET_PC at top of address space ----------------
  logic        pc_sel_1 = 1'b0;
  logic [31:0] pc_target_1 = 32'd0;
  logic        instr_ack_1 = 1'b0;
  logic        imem_rvalid_1 = 1'b0;
  logic [31:0] imem_rdata_1 = 32'd0;
  logic        imem_req_1;
  logic [31:0] imem_addr_1;
  logic [31:0] instr_1;
  logic        instr_valid_1;
  logic [31:0] pc_1;
  logic [31:0] pc_plus4_1;
  logic        fault_1;
  logic [31:0] retire_cnt_1;
  state_t      state_dbg_1;

  pc_fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .CLK(clk), .RST(rst), .PC_Sel(pc_sel_1), .PC_TARGET(pc_target_1), .INSTR_ACK(instr_ack_1),
    .IMEM_REQ(imem_req_1), .IMEM_ADDR(imem_addr_1), .IMEM_RVALID(imem_rvalid_1),
    .IMEM_RDATA(imem_rdata_1), .INSTR(instr_1), .INSTR_VALID(instr_valid_1), .PC(pc_1),
    .PC_PLUS4(pc_plus4_1), .FAULT(fault_1), .RETIRE_CNT(retire_cnt_1), .state_dbg(state_dbg_1)
  );

  // ---------------- scoreboard ----------------
  int          total  = 0;
  int          passed = 0;
  logic [63:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  // Monitor: every rising INSTR_VALID must present the next expected {PC, INSTR}.
  logic        prev_valid = 1'b0;
  logic [63:0] exp_e;
  always @(negedge clk) begin
    if (instr_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL sb_unexpected: instr_valid rose with pc %08h, no entry expected", pc);
      end else begin
        exp_e = exp_q.pop_front();
        chk("sb_pc", pc, exp_e[63:32]);
        chk("sb_instr", instr, exp_e[31:0]);
      end
    end
    prev_valid = instr_valid;
  end

  // ---------------- driver tasks (called and returning at a negedge) ----------------
  task automatic do_fetch(input int dly, input logic [31:0] exp_addr, input logic [31:0] data);
    int n = 0;
    int held = 0;
    while (!imem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!imem_req) begin
      total++;
      $display("FAIL req_timeout: imem_req still 0 after %0d cycles, expected 1", n);
      return;
    end
    chk("fetch_addr", imem_addr, exp_addr);
    for (int i = 0; i < dly; i++) begin
      if (imem_req && imem_addr == exp_addr) held++;
      @(negedge clk);
    end
    if (imem_req && imem_addr == exp_addr) held++;
    exp_q.push_back({exp_addr, data});
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    @(negedge clk);
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    chk("valid_latency", {31'd0, instr_valid}, 32'd1);
    chk("req_drop", {31'd0, imem_req}, 32'd0);
    if (dly > 0) chk("req_hold", held, dly + 1);
  endtask

  task automatic do_ack(input int dly, input logic [31:0] exp_pc, input logic [31:0] exp_instr,
                        input logic sel, input logic [31:0] tgt);
    for (int i = 0; i < dly; i++) begin
      instr_ack = 1'b0;
      pc_sel    = 1'($urandom_range(0, 1));
      pc_target = $urandom;
      chk("exec_pc", pc, exp_pc);
      chk("exec_instr", instr, exp_instr);
      @(negedge clk);
    end
    instr_ack = 1'b1;
    pc_sel    = sel;
    pc_target = tgt;
    @(negedge clk);
    instr_ack = 1'b0;
    pc_sel    = 1'($urandom_range(0, 1));
    pc_target = $urandom;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    chk("rst_pc", pc, 32'h0);
    chk("rst_pc_plus4", pc_plus4, 32'h4);
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_retire", retire_cnt, 32'd0);
    chk("rst_state", 32'(state_dbg), 32'(S_IDLE));
    chk("rst_wrap_pc", pc_1, 32'hFFFF_FFFC);
    chk("rst_wrap_pc_plus4", pc_plus4_1, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("first_req", {31'd0, imem_req}, 32'd1);
    chk("first_state", 32'(state_dbg), 32'(S_REQ));

    // Zero-wait sequential fetches.
    do_fetch(0, 32'h0, 32'h0000_0013);
    do_ack(0, 32'h0, 32'h0000_0013, 1'b0, 32'h0);
    do_fetch(0, 32'h4, 32'h0000_0013);
    do_ack(0, 32'h4, 32'h0000_0013, 1'b0, 32'h0);
    do_fetch(0, 32'h8, 32'h0000_0013);
    do_ack(0, 32'h8, 32'h0000_0013, 1'b0, 32'h0);
    chk("retire_3", retire_cnt, 32'd3);
    chk("pc_after_3", pc, 32'hC);

    // Slow memory, then a taken branch to an odd target.
    do_fetch(3, 32'hC, 32'h0050_0093);
    do_ack(1, 32'hC, 32'h0050_0093, 1'b1, 32'h0000_0101);
    chk("br_pc", pc, 32'h100);
    chk("br_pc_plus4", pc_plus4, 32'h104);
    chk("br_addr", imem_addr, 32'h100);
    chk("br_retire", retire_cnt, 32'd4);

    // Misaligned target: sticky fault.
    do_fetch(1, 32'h100, 32'h0000_006F);
    do_ack(2, 32'h100, 32'h0000_006F, 1'b1, 32'h0000_0202);
    chk("fault_set", {31'd0, fault}, 32'd1);
    chk("fault_pc", pc, 32'h100);
    chk("fault_req", {31'd0, imem_req}, 32'd0);
    chk("fault_valid", {31'd0, instr_valid}, 32'd0);
    chk("fault_retire", retire_cnt, 32'd5);
    chk("fault_state", 32'(state_dbg), 32'(S_FAULT));
    for (int i = 0; i < 4; i++) begin
      imem_rvalid = 1'($urandom_range(0, 1));
      instr_ack   = 1'b1;
      pc_sel      = 1'b0;
      @(negedge clk);
    end
    imem_rvalid = 1'b0;
    instr_ack   = 1'b0;
    chk("fault_sticky", {31'd0, fault}, 32'd1);
    chk("fault_sticky_req", {31'd0, imem_req}, 32'd0);
    chk("fault_sticky_pc", pc, 32'h100);
    chk("fault_sticky_retire", retire_cnt, 32'd5);

    // Reset clears the fault without a clock edge.
    #2 rst = 1'b1;
    #1 chk("fault_clear", {31'd0, fault}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_fetch(0, 32'h0, 32'h0000_0013);
    do_ack(0, 32'h0, 32'h0000_0013, 1'b0, 32'h0);

    // INSTR_ACK while waiting for memory is ignored.
    for (int i = 0; i < 2; i++) begin
      instr_ack = 1'b1;
      pc_sel    = 1'b1;
      pc_target = 32'h40;
      @(negedge clk);
    end
    instr_ack = 1'b0;
    chk("req_ack_pc", pc, 32'h4);
    chk("req_ack_retire", retire_cnt, 32'd1);
    chk("req_ack_addr", imem_addr, 32'h4);
    chk("req_ack_req", {31'd0, imem_req}, 32'd1);

    // Asynchronous reset in the middle of a request.
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_req", {31'd0, imem_req}, 32'd0);
    chk("rst_mid_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_mid_pc", pc, 32'h0);
    chk("rst_mid_retire", retire_cnt, 32'd0);
    chk("rst_mid_state", 32'(state_dbg), 32'(S_IDLE));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Asynchronous reset while an instruction is presented.
    do_fetch(0, 32'h0, 32'hDEAD_BEEF);
    #2 rst = 1'b1;
    #1;
    chk("rst_exec_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_exec_instr", instr, 32'h0000_0013);
    chk("rst_exec_pc", pc, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // PC+4 wraps from the top of the address space.
    chk("wrap_req", {31'd0, imem_req_1}, 32'd1);
    chk("wrap_addr0", imem_addr_1, 32'hFFFF_FFFC);
    imem_rvalid_1 = 1'b1;
    imem_rdata_1  = 32'h0000_0013;
    @(negedge clk);
    imem_rvalid_1 = 1'b0;
    chk("wrap_valid", {31'd0, instr_valid_1}, 32'd1);
    instr_ack_1 = 1'b1;
    pc_sel_1    = 1'b0;
    @(negedge clk);
    instr_ack_1 = 1'b0;
    chk("wrap_addr1", imem_addr_1, 32'h0);
    chk("wrap_req1", {31'd0, imem_req_1}, 32'd1);
    chk("wrap_fault", {31'd0, fault_1}, 32'd0);
    chk("wrap_pc_plus4", pc_plus4_1, 32'h4);
    chk("wrap_retire", retire_cnt_1, 32'd1);

    @(negedge clk);
    chk("sb_drain", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
